rgb_frame_streamer: RTL
=======================

# rgb_frame_streamer

Transmit side of the RGB pixel-valid stream consumed by the image-processing blocks (image arithmetic, grayscale, etc.). On a start pulse it reads one frame, raster order, from a 24-bit-wide frame memory with 1-cycle read latency. It emits each pixel as registered red/green/blue bytes with a valid strobe, plus frame and line markers. Horizontal blanking is inserted between lines, and the controller can pause the stream.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥1)
- H_BLANK, 16, idle cycles inserted after each line except the last (0 allowed)
- ADDR_W, 19, memory address width (≥ clog2(IMG_WIDTH*IMG_HEIGHT))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- RGB_enable  in  1  high = run; low = pause issuing reads (driven by controller)
- start  in  1  one-cycle pulse, begins a frame when idle
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  linear pixel address, y*IMG_WIDTH+x
- mem_rdata  in  24  read data, valid the cycle after mem_rd_en; [23:16]=R, [15:8]=G, [7:0]=B
- out_red_pixel  out  8  red pixel
- out_green_pixel  out  8  green pixel
- out_blue_pixel  out  8  blue pixel
- RGB_valid_out  out  1  pixel outputs valid this cycle
- sof_out  out  1  high with the first pixel of the frame
- eol_out  out  1  high with the last pixel of each line
- frame_done  out  1  one-cycle pulse with the last pixel of the frame
- busy  out  1  high from start acceptance until frame_done

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, DRAIN.
- IDLE:
  - start=1 → ACTIVE; address, x and y counters cleared; busy=1.
  - start is not gated by RGB_enable.
- ACTIVE:
  - When RGB_enable=1: assert mem_rd_en at mem_addr, then increment mem_addr and x.
  - When RGB_enable=0: mem_rd_en=0 and all counters hold.
  - At x=IMG_WIDTH-1 with a read issued:
    - last line (y=IMG_HEIGHT-1) → DRAIN;
    - otherwise, H_BLANK>0 → HBLANK;
    - otherwise (H_BLANK=0) → stay in ACTIVE.
  - In each non-last case: x←0, y←y+1.
- HBLANK:
  - Counts H_BLANK cycles with no reads, then → ACTIVE.
  - The blank counter advances only while RGB_enable=1.
- DRAIN:
  - Waits for the in-flight pipeline to empty (2 cycles).
  - Then → IDLE and busy=0 in the cycle after frame_done.
- Sideband tags (sof, eol, last) travel alongside each read through the pipeline, so markers align exactly with their pixel.
- In-flight pixels are always delivered, including when RGB_enable falls. Pausing never drops or duplicates a pixel.
- start is ignored when not IDLE.
- No arithmetic on pixel data. Bytes pass through unchanged from mem_rdata.

## Timing
- Reset values of all outputs: 0. mem_addr=0; FSM=IDLE.
- Latency: mem_rd_en at cycle t → mem_rdata at t+1 → registered outputs and RGB_valid_out at t+2.
- First pixel: start sampled at cycle s → first mem_rd_en at s+1 → first RGB_valid_out (with sof_out) at s+3.
- Throughput: one pixel per cycle while enabled in ACTIVE.
- Line period: IMG_WIDTH + H_BLANK cycles, with no pauses.
- Outputs are undefined-but-stable when RGB_valid_out=0: they hold their last value.
- Reset mid-frame returns immediately to IDLE. All strobes clear and pipeline contents are discarded.

## Structure
- Shared image package holds:
  - FSM state encoding;
  - the 24-bit pixel packing constants (R/G/B bit positions);
  - the pixel-word width.
- One sub-module: `pixel_tag_pipe`, a 2-stage valid/sof/eol/last shift register aligned with memory latency.
- Counters, FSM and output register stay in the top module.

## Test plan
Use IMG_WIDTH=4, IMG_HEIGHT=3, H_BLANK=2 unless stated. The memory model returns {addr[7:0], ~addr[7:0], addr[7:0]+8'h10}.
- Basic frame:
  - start pulse → 12 valid pixels at addresses 0..11 in order.
  - Lines separated by exactly 2 invalid cycles.
  - sof_out with pixel 0; eol_out with pixels 3, 7, 11.
  - frame_done with pixel 11; busy falls the next cycle.
- Data mapping: pixel at address 5 → out_red=8'h05, out_green=8'hFA, out_blue=8'h15.
- Pause:
  - Drop RGB_enable for 5 cycles mid-line after address 1 is issued.
  - Address 1 is still delivered.
  - No reads occur during the pause.
  - Resume issues address 2.
  - Total valid count stays 12 with no duplicates.
- H_BLANK=0: 12 consecutive valid cycles with no gaps; eol_out on pixels 3, 7, 11.
- start while busy: a second start during line 1 is ignored, giving exactly one frame_done and 12 pixels.
- Reset mid-frame:
  - Assert rst_n=0 during line 1 → all outputs 0 immediately.
  - After release, a new start begins at mem_addr=0 with sof_out on the first pixel.

Source files
------------

// File: rtl/rgb_frame_streamer_pkg.sv
// Shared image package for the RGB pixel-valid stream.
// Holds the streamer FSM encoding, the 24-bit pixel packing layout
// (R in the top byte, B in the bottom byte), and the per-pixel sideband tag.
package rgb_frame_streamer_pkg;

    // FSM encoding, kept as plain constants so older blocks can compare raw values
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Pixel word layout
    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // Markers that ride with each read so they line up with their pixel
    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } pix_tag_t;

endpackage

// File: rtl/rgb_frame_streamer_if.sv
// Bus bundle for rgb_frame_streamer.
//   controller side : RGB_enable, start, busy, frame_done
//   memory side     : mem_rd_en, mem_addr, mem_rdata (1-cycle read latency)
//   pixel stream    : out_red/green/blue_pixel, RGB_valid_out, sof_out, eol_out
// master = the streamer, slave = memory/controller/consumer side.
interface rgb_frame_streamer_if #(
    parameter int ADDR_W = 19
);
    import rgb_frame_streamer_pkg::*;

    logic              RGB_enable;
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [CH_W-1:0]   out_red_pixel;
    logic [CH_W-1:0]   out_green_pixel;
    logic [CH_W-1:0]   out_blue_pixel;
    logic              RGB_valid_out;
    logic              sof_out;
    logic              eol_out;
    logic              frame_done;
    logic              busy;

    modport master (
        input  RGB_enable, start, mem_rdata,
        output mem_rd_en, mem_addr, out_red_pixel, out_green_pixel, out_blue_pixel,
               RGB_valid_out, sof_out, eol_out, frame_done, busy
    );

    modport slave (
        output RGB_enable, start, mem_rdata,
        input  mem_rd_en, mem_addr, out_red_pixel, out_green_pixel, out_blue_pixel,
               RGB_valid_out, sof_out, eol_out, frame_done, busy
    );

endinterface

// File: rtl/rgb_frame_streamer_pixel_tag_pipe.sv
// pixel_tag_pipe: 2-stage valid + sideband tag shift register matching the
// memory read latency plus the output register.
//   in_vld/in_tag : read issued this cycle and its markers
//   mid_vld       : read data is on mem_rdata this cycle (load output register)
//   out_vld/out_tag : aligned with the registered pixel outputs
module pixel_tag_pipe
    import rgb_frame_streamer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_vld,
    input  pix_tag_t in_tag,
    output logic     mid_vld,
    output logic     out_vld,
    output pix_tag_t out_tag
);
    localparam int STAGES = 2;

    logic     [STAGES:1] vld_pipe;
    pix_tag_t [STAGES:1] tag_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
            tag_pipe <= {tag_pipe[STAGES-1:1], in_tag};
        end
    end

    assign mid_vld = vld_pipe[1];
    assign out_vld = vld_pipe[STAGES];
    assign out_tag = tag_pipe[STAGES];

endmodule

// File: rtl/rgb_frame_streamer.sv
// rgb_frame_streamer: reads one frame in raster order from a 24-bit frame
// memory and emits it as a registered R/G/B pixel-valid stream with
// sof/eol markers, horizontal blanking between lines and pause support.
//   clk, rst_n : clock, async active-low reset
//   bus        : controller, memory and pixel-stream signals (master side)
module rgb_frame_streamer
    import rgb_frame_streamer_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int H_BLANK    = 16,
    parameter int ADDR_W     = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rgb_frame_streamer_if.master bus
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BW = $clog2(H_BLANK + 2);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    logic [1:0]        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     blank_cnt;

    logic     issue, line_end, frame_end;
    pix_tag_t issue_tag, out_tag;
    logic     mid_vld, out_vld;
    logic [CH_W-1:0] red_q, green_q, blue_q;

    // A read goes out every enabled ACTIVE cycle; pausing just withholds it.
    assign issue     = (state == ST_ACTIVE) && bus.RGB_enable;
    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);

    always_comb begin
        issue_tag      = '0;
        issue_tag.sof  = issue && (x == '0) && (y == '0);
        issue_tag.eol  = issue && line_end;
        issue_tag.last = issue && frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            blank_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_ACTIVE;
                        x     <= '0;
                        y     <= '0;
                        addr  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.RGB_enable) begin
                        addr <= addr + 1'b1;
                        if (line_end) begin
                            if (y == Y_LAST) begin
                                state <= ST_DRAIN;
                            end else begin
                                x         <= '0;
                                y         <= y + 1'b1;
                                blank_cnt <= '0;
                                if (H_BLANK > 0) state <= ST_HBLANK;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (bus.RGB_enable) begin
                        blank_cnt <= blank_cnt + 1'b1;
                        if (blank_cnt == B_LAST) state <= ST_ACTIVE;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the last pixel is on the outputs, so busy
                    // drops the cycle after frame_done.
                    if (out_vld && out_tag.last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pixel_tag_pipe u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue),
        .in_tag  (issue_tag),
        .mid_vld (mid_vld),
        .out_vld (out_vld),
        .out_tag (out_tag)
    );

    // Output register loads only with real data, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (mid_vld) begin
            red_q   <= bus.mem_rdata[R_LSB +: CH_W];
            green_q <= bus.mem_rdata[G_LSB +: CH_W];
            blue_q  <= bus.mem_rdata[B_LSB +: CH_W];
        end
    end

    assign bus.mem_rd_en       = issue;
    assign bus.mem_addr        = addr;
    assign bus.out_red_pixel   = red_q;
    assign bus.out_green_pixel = green_q;
    assign bus.out_blue_pixel  = blue_q;
    assign bus.RGB_valid_out   = out_vld;
    assign bus.sof_out         = out_vld && out_tag.sof;
    assign bus.eol_out         = out_vld && out_tag.eol;
    assign bus.frame_done      = out_vld && out_tag.last;
    assign bus.busy            = (state != ST_IDLE);

endmodule
